// File: rtl/rv32i_instr_encoder.sv
// RV32I micro-op to instruction-word encoder. It range-checks the operands and queues each legal
// word with its IROM word address in a small FIFO.
module rv32i_instr_encoder #(
   parameter int          DEPTH     = 2,
   parameter int          ADDR_W    = 12,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err_illegal,
   output logic [5:0]        err_op
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef enum logic [5:0] {
      OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW,
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
      OP_SLLI, OP_SRLI, OP_SRAI,
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
   } op_e;

   typedef enum logic [3:0] {
      FMT_BAD, FMT_NOP, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
   } fmt_e;

   fmt_e              fmt;
   logic [6:0]        opc;
   logic [2:0]        f3;
   logic [6:0]        f7;
   logic [31:0]       word;
   logic              legal;
   logic              fits_i, fits_b, fits_j, fits_u, fits_sh;

   logic [31:0]       mem_instr [DEPTH];
   logic [ADDR_W-1:0] mem_addr  [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] addr_q;
   logic              rdy_q;
   logic              full, accept, push, pop;

   // Mnemonic to format and fixed fields.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      fmt = FMT_BAD;
      opc = '0;
      f3  = '0;
      f7  = '0;
      case (op_e'(in_op))
         OP_NOP:   fmt = FMT_NOP;
         OP_LUI:   begin fmt = FMT_U;  opc = OPC_LUI;                 end
         OP_AUIPC: begin fmt = FMT_U;  opc = OPC_AUIPC;               end
         OP_JAL:   begin fmt = FMT_J;  opc = OPC_JAL;                 end
         OP_JALR:  begin fmt = FMT_I;  opc = OPC_JALR;   f3 = 3'b000; end
         OP_BEQ:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b000; end
         OP_BNE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b001; end
         OP_BLT:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b100; end
         OP_BGE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b101; end
         OP_BLTU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b110; end
         OP_BGEU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b111; end
         OP_LB:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b000; end
         OP_LH:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b001; end
         OP_LW:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b010; end
         OP_LBU:   begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b100; end
         OP_LHU:   begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b101; end
         OP_SB:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'b000; end
         OP_SH:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'b001; end
         OP_SW:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'b010; end
         OP_ADDI:  begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'b000; end
         OP_SLTI:  begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'b010; end
         OP_SLTIU: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'b011; end
         OP_XORI:  begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'b100; end
         OP_ORI:   begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'b110; end
         OP_ANDI:  begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'b111; end
         OP_SLLI:  begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = 3'b001; end
         OP_SRLI:  begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = 3'b101; end
         OP_SRAI:  begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = 3'b101; f7 = F7_ALT; end
         OP_ADD:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b000; end
         OP_SUB:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b000; f7 = F7_ALT; end
         OP_SLL:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b001; end
         OP_SLT:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b010; end
         OP_SLTU:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b011; end
         OP_XOR:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b100; end
         OP_SRL:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b101; end
         OP_SRA:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b101; f7 = F7_ALT; end
         OP_OR:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b110; end
         OP_AND:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b111; end
         default:  fmt = FMT_BAD;
      endcase
   end

   // A signed value fits when every bit above the field's sign bit matches it.
   assign fits_i  = (in_imm[31:11] == {21{in_imm[11]}});
   assign fits_b  = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
   assign fits_j  = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
   assign fits_u  = (in_imm[11:0] == 12'd0);
   assign fits_sh = (in_imm[31:5] == 27'd0);

   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (fmt)
         FMT_NOP: word = 32'h0000_0013;
         FMT_R:   word = {f7, in_rs2, in_rs1, f3, in_rd, opc};
         FMT_I:   begin legal = fits_i;  word = {in_imm[11:0], in_rs1, f3, in_rd, opc}; end
         FMT_SH:  begin legal = fits_sh; word = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc}; end
         FMT_S:   begin
            legal = fits_i;
            word  = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
         end
         FMT_B:   begin
            legal = fits_b;
            word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
         end
         FMT_U:   begin legal = fits_u;  word = {in_imm[31:12], in_rd, opc}; end
         FMT_J:   begin
            legal = fits_j;
            word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
         end
         default: legal = 1'b0;
      endcase
   end

   assign full      = (count == CNT_W'(DEPTH));
   assign in_ready  = rdy_q && !full && !flush;
   assign accept    = in_valid && in_ready;
   assign push      = accept && legal;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready && !flush;
   assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
   assign out_addr  = out_valid ? mem_addr[rd_ptr]  : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         rdy_q       <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         addr_q      <= ADDR_W'(BASE_ADDR);
         err_illegal <= 1'b0;
         err_op      <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            addr_q      <= ADDR_W'(BASE_ADDR);
            err_illegal <= 1'b0;
            err_op      <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
               addr_q <= addr_q + ADDR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
            if (accept && !legal) begin
               err_illegal <= 1'b1;
               if (!err_illegal) err_op <= in_op;
            end
         end
      end
   end

   // NOTE: FIFO storage is not reset; count and pointers gate every read, so stale data never leaks.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= word;
         mem_addr[wr_ptr]  <= addr_q;
      end
   end

endmodule
